// File: rtl/load_align_if.sv
// Bundle of the request, memory-port and response signals around load_align_unit.
// The slave modport is the unit's view. The master modport is the core/memory environment's view.
interface load_align_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic [2:0]      req_funct3;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_fault;

  modport slave (
    input  req_valid, req_addr, req_funct3, mem_rvalid, mem_rdata, rsp_ready,
    output req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_fault
  );

  modport master (
    output req_valid, req_addr, req_funct3, mem_rvalid, mem_rdata, rsp_ready,
    input  req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_fault
  );
endinterface

// File: rtl/load_align_unit.sv
// Load-data aligner: takes one load at a time and issues one or two word-aligned reads.
// It returns the extracted byte/half/word/double, sign- or zero-extended.
module load_align_unit #(
  parameter int unsigned XLEN          = 32,
  parameter bit          MISALIGNED_EN = 1'b1
) (
  input logic         clk,
  input logic         rst,
  load_align_if.slave bus
);

  localparam int unsigned B    = XLEN / 8;
  localparam int unsigned OffW = $clog2(B);
  localparam int unsigned EndW = OffW + 1;
  localparam int unsigned ShW  = $clog2(2 * XLEN);

  typedef enum logic [2:0] {StIdle, StReq0, StWait0, StReq1, StWait1, StResp} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      size_q, size_d;     // log2 of access size in bytes
  logic            uns_q, uns_d;
  logic            cross_q, cross_d;
  logic [XLEN-1:0] word0_q, word0_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_fault_q, rsp_fault_d;

  logic            req_legal;
  logic [1:0]      req_size;
  logic            req_uns;
  logic [EndW-1:0] req_end;
  logic            req_cross;

  logic [XLEN-1:0]   aligned_addr;
  logic [XLEN-1:0]   mrg_w0, mrg_w1;
  logic [2*XLEN-1:0] shifted;
  logic [7:0]        nbits;
  logic [XLEN-1:0]   keep_mask;
  logic [ShW-1:0]    msb_idx;
  logic              sign_bit;
  logic [XLEN-1:0]   merged;

  // Decode the incoming funct3 into size/signedness and legality, and detect word crossing
  always_comb begin
    req_legal = 1'b1;
    req_size  = 2'd0;
    req_uns   = 1'b0;
    case (bus.req_funct3)
      3'b000: req_size = 2'd0;
      3'b001: req_size = 2'd1;
      3'b010: req_size = 2'd2;
      3'b011: begin
        req_size  = 2'd3;
        req_legal = (XLEN == 64);
      end
      3'b100: begin
        req_size = 2'd0;
        req_uns  = 1'b1;
      end
      3'b101: begin
        req_size = 2'd1;
        req_uns  = 1'b1;
      end
      3'b110: begin
        req_size  = 2'd2;
        req_uns   = 1'b1;
        req_legal = (XLEN == 64);
      end
      default: req_legal = 1'b0;
    endcase
    req_end   = {1'b0, bus.req_addr[OffW-1:0]} + (EndW'(1) << req_size);
    req_cross = req_end > EndW'(B);
  end

  // Merge {word1, word0}, shift down by the byte offset, then mask and extend to XLEN
  always_comb begin
    if (state_q == StWait1) begin
      mrg_w0 = word0_q;
      mrg_w1 = bus.mem_rdata;
    end else begin
      mrg_w0 = bus.mem_rdata;
      mrg_w1 = '0;
    end
    shifted   = {mrg_w1, mrg_w0} >> {addr_q[OffW-1:0], 3'b000};
    nbits     = 8'd8 << size_q;
    // A shift by the full width yields zero, so a full-width access keeps every bit
    keep_mask = ~({XLEN{1'b1}} << nbits);
    msb_idx   = ShW'(nbits - 8'd1);
    sign_bit  = ~uns_q & shifted[msb_idx];
    merged    = (shifted[XLEN-1:0] & keep_mask) | (~keep_mask & {XLEN{sign_bit}});
  end

  // Next-state and captured-data logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    cross_d     = cross_q;
    word0_d     = word0_q;
    rsp_data_d  = rsp_data_q;
    rsp_fault_d = rsp_fault_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          size_d  = req_size;
          uns_d   = req_uns;
          cross_d = req_cross;
          if (!req_legal || (req_cross && !MISALIGNED_EN)) begin
            rsp_data_d  = '0;
            rsp_fault_d = 1'b1;
            state_d     = StResp;
          end else begin
            state_d = StReq0;
          end
        end
      end
      StReq0: state_d = StWait0;
      StWait0: begin
        if (bus.mem_rvalid) begin
          word0_d = bus.mem_rdata;
          if (cross_q) begin
            state_d = StReq1;
          end else begin
            rsp_data_d  = merged;
            rsp_fault_d = 1'b0;
            state_d     = StResp;
          end
        end
      end
      StReq1: state_d = StWait1;
      StWait1: begin
        if (bus.mem_rvalid) begin
          rsp_data_d  = merged;
          rsp_fault_d = 1'b0;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      cross_q     <= 1'b0;
      word0_q     <= '0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      cross_q     <= cross_d;
      word0_q     <= word0_d;
      rsp_data_q  <= rsp_data_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign aligned_addr = {addr_q[XLEN-1:OffW], {OffW{1'b0}}};

  // Handshake and memory-port outputs decoded from the state
  always_comb begin
    bus.req_ready = (state_q == StIdle) && !rst;
    bus.mem_req   = (state_q == StReq0) || (state_q == StReq1);
    bus.mem_addr  = '0;
    if (state_q == StReq0) bus.mem_addr = aligned_addr;
    if (state_q == StReq1) bus.mem_addr = aligned_addr + XLEN'(B);  // wraps modulo 2^XLEN
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_data  = rsp_data_q;
    bus.rsp_fault = rsp_fault_q;
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit at XLEN=32 with a one-cycle-latency memory model.
module tb_load_align_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_align_if #(.XLEN(32)) bus_a ();
  load_align_if #(.XLEN(32)) bus_b ();

  load_align_unit #(.XLEN(32), .MISALIGNED_EN(1'b1)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  load_align_unit #(.XLEN(32), .MISALIGNED_EN(1'b0)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  logic stall_a = 1'b0;
  logic inject_a = 1'b0;
  logic [31:0] log_a[$];
  logic [31:0] log_b[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hDDCC_BBAA;
      32'h0000_0104: return 32'h4433_2211;
      32'hFFFF_FFFC: return 32'h7700_0000;
      32'h0000_0000: return 32'h0000_80AA;
      default:       return 32'h0;
    endcase
  endfunction

  // Memory model: rvalid one cycle after each strobe, plus a request log
  always @(posedge clk) begin
    bus_a.mem_rvalid <= (bus_a.mem_req & ~stall_a) | inject_a;
    bus_a.mem_rdata  <= mem_word(bus_a.mem_addr);
    if (bus_a.mem_req) log_a.push_back(bus_a.mem_addr);
    bus_b.mem_rvalid <= bus_b.mem_req;
    bus_b.mem_rdata  <= mem_word(bus_b.mem_addr);
    if (bus_b.mem_req) log_b.push_back(bus_b.mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one load on unit A, wait for the response, check it, then retire it
  task automatic run_a(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] exp_data, input logic exp_fault, input int exp_lat,
                       input int exp_n, input logic [31:0] exp_a0, input logic [31:0] exp_a1);
    int lat;
    log_a.delete();
    chk({tag, ":req_ready"}, 32'(bus_a.req_ready), 32'd1);
    bus_a.req_valid  = 1'b1;
    bus_a.req_addr   = addr;
    bus_a.req_funct3 = f3;
    tick();
    bus_a.req_valid = 1'b0;
    lat = 1;
    while (!bus_a.rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":data"}, bus_a.rsp_data, exp_data);
    chk({tag, ":fault"}, 32'(bus_a.rsp_fault), 32'(exp_fault));
    chk({tag, ":nreq"}, 32'(log_a.size()), 32'(exp_n));
    if (exp_n > 0 && log_a.size() > 0) chk({tag, ":addr0"}, log_a[0], exp_a0);
    if (exp_n > 1 && log_a.size() > 1) chk({tag, ":addr1"}, log_a[1], exp_a1);
    bus_a.rsp_ready = 1'b1;
    tick();
    bus_a.rsp_ready = 1'b0;
    chk({tag, ":done_valid"}, 32'(bus_a.rsp_valid), 32'd0);
    chk({tag, ":done_ready"}, 32'(bus_a.req_ready), 32'd1);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    bus_a.req_valid = 1'b0; bus_a.req_addr = '0; bus_a.req_funct3 = '0; bus_a.rsp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.req_funct3 = '0; bus_b.rsp_ready = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst:req_ready", 32'(bus_a.req_ready), 32'd0);
    chk("rst:mem_req", 32'(bus_a.mem_req), 32'd0);
    chk("rst:mem_addr", bus_a.mem_addr, 32'd0);
    chk("rst:rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    chk("rst:rsp_data", bus_a.rsp_data, 32'd0);
    chk("rst:rsp_fault", 32'(bus_a.rsp_fault), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst:req_ready", 32'(bus_a.req_ready), 32'd1);
    tick();

    run_a("lb_101",  32'h101, 3'b000, 32'hFFFF_FFBB, 1'b0, 3, 1, 32'h100, 32'h0);
    run_a("lbu_101", 32'h101, 3'b100, 32'h0000_00BB, 1'b0, 3, 1, 32'h100, 32'h0);
    run_a("lh_102",  32'h102, 3'b001, 32'hFFFF_DDCC, 1'b0, 3, 1, 32'h100, 32'h0);
    run_a("lh_103",  32'h103, 3'b001, 32'h0000_11DD, 1'b0, 5, 2, 32'h100, 32'h104);
    run_a("lw_102",  32'h102, 3'b010, 32'h2211_DDCC, 1'b0, 5, 2, 32'h100, 32'h104);
    run_a("lhu_104", 32'h106, 3'b101, 32'h0000_4433, 1'b0, 3, 1, 32'h104, 32'h0);
    run_a("ld_rv32", 32'h100, 3'b011, 32'h0,         1'b1, 1, 0, 32'h0,   32'h0);
    run_a("lwu_rv32", 32'h100, 3'b110, 32'h0,        1'b1, 1, 0, 32'h0,   32'h0);
    run_a("lh_wrap", 32'hFFFF_FFFF, 3'b001, 32'hFFFF_AA77, 1'b0, 5, 2, 32'hFFFF_FFFC, 32'h0);

    // Misaligned disabled: crossing word load faults without touching memory
    log_b.delete();
    bus_b.req_valid  = 1'b1;
    bus_b.req_addr   = 32'h102;
    bus_b.req_funct3 = 3'b010;
    tick();
    bus_b.req_valid = 1'b0;
    chk("noalign:rsp_valid", 32'(bus_b.rsp_valid), 32'd1);
    chk("noalign:fault", 32'(bus_b.rsp_fault), 32'd1);
    chk("noalign:data", bus_b.rsp_data, 32'd0);
    tick();
    chk("noalign:nreq", 32'(log_b.size()), 32'd0);
    bus_b.rsp_ready = 1'b1;
    tick();
    bus_b.rsp_ready = 1'b0;
    chk("noalign:req_ready", 32'(bus_b.req_ready), 32'd1);

    // Response backpressure
    bus_a.req_valid  = 1'b1;
    bus_a.req_addr   = 32'h101;
    bus_a.req_funct3 = 3'b000;
    tick();
    bus_a.req_valid = 1'b0;
    lat = 1;
    while (!bus_a.rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("bp:latency", 32'(lat), 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk("bp:rsp_valid", 32'(bus_a.rsp_valid), 32'd1);
      chk("bp:rsp_data", bus_a.rsp_data, 32'hFFFF_FFBB);
      chk("bp:rsp_fault", 32'(bus_a.rsp_fault), 32'd0);
      chk("bp:req_ready", 32'(bus_a.req_ready), 32'd0);
      tick();
    end
    bus_a.rsp_ready = 1'b1;
    tick();
    bus_a.rsp_ready = 1'b0;
    chk("bp:idle_ready", 32'(bus_a.req_ready), 32'd1);
    chk("bp:idle_valid", 32'(bus_a.rsp_valid), 32'd0);

    // Reset while waiting for the second word of a crossing halfword
    log_a.delete();
    bus_a.req_valid  = 1'b1;
    bus_a.req_addr   = 32'h103;
    bus_a.req_funct3 = 3'b001;
    tick();                  // REQ0
    bus_a.req_valid = 1'b0;
    tick();                  // WAIT0, first word arrives
    stall_a = 1'b1;
    tick();                  // REQ1
    tick();                  // WAIT1, second word withheld
    chk("midrst:nreq", 32'(log_a.size()), 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst:req_ready", 32'(bus_a.req_ready), 32'd0);
    chk("midrst:mem_req", 32'(bus_a.mem_req), 32'd0);
    chk("midrst:mem_addr", bus_a.mem_addr, 32'd0);
    chk("midrst:rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    chk("midrst:rsp_data", bus_a.rsp_data, 32'd0);
    chk("midrst:rsp_fault", 32'(bus_a.rsp_fault), 32'd0);
    tick();
    rst = 1'b0;
    inject_a = 1'b1;
    tick();                  // late rvalid visible this cycle
    inject_a = 1'b0;
    chk("late_rvalid:rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    tick();
    chk("late_rvalid:rsp_valid2", 32'(bus_a.rsp_valid), 32'd0);
    stall_a = 1'b0;
    run_a("lw_after_rst", 32'h100, 3'b010, 32'hDDCC_BBAA, 1'b0, 3, 1, 32'h100, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Sequential, parametrised load-data aligner between the core's memory stage and the data-memory port. It accepts one load request at a time, issues one or two word-aligned reads, and returns the extracted, sign- or zero-extended result through a valid/ready handshake. Unlike a purely combinational lane mux, it supports XLEN = 32 or 64 (adds ld/lwu) and loads that cross a word boundary, which it splits into two back-to-back reads.

## Interface
- XLEN, 32: datapath and bus width. Legal values are 32 and 64. Bus word size is B = XLEN/8 bytes.
- MISALIGNED_EN, 1: 1 splits word-crossing loads into two reads. 0 faults them with no memory access.
- clk  input  1  system clock. All state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  load request present.
- req_ready  output  1  unit can accept a request. High only in IDLE.
- req_addr  input  XLEN  byte address.
- req_funct3  input  3  RISC-V load funct3.
- mem_req  output  1  one-cycle read strobe.
- mem_addr  output  XLEN  word-aligned read address. Low log2(B) bits are 0.
- mem_rvalid  input  1  read data valid, at least 1 cycle after mem_req.
- mem_rdata  input  XLEN  read data, little-endian.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_data  output  XLEN  extended load result.
- rsp_fault  output  1  illegal funct3 or disallowed misaligned access.

## Operation
- **Sizes:**
  - 000 lb = 1 byte, signed. 100 lbu = 1 byte, unsigned.
  - 001 lh = 2 bytes, signed. 101 lhu = 2 bytes, unsigned.
  - 010 lw = 4 bytes, signed when XLEN=64.
  - XLEN=64 only: 011 ld = 8 bytes; 110 lwu = 4 bytes, unsigned.
  - Any other code is illegal, including 011/110 when XLEN=32.
- **Capture:** on a handshake (req_valid & req_ready), the unit registers address, funct3, offset = addr[log2(B)-1:0] and size S.
- **Crossing:** a load crosses a word boundary when offset + S > B.
- **States:**
  - IDLE → RESP with fault, if funct3 is illegal, or if it crosses and MISALIGNED_EN=0.
  - IDLE → REQ0, otherwise.
  - REQ0: mem_req=1, mem_addr = aligned address. → WAIT0.
  - WAIT0: on mem_rvalid, capture word0. → REQ1 if crossing, else → RESP.
  - REQ1: mem_req=1, mem_addr = aligned address + B. → WAIT1.
  - WAIT1: on mem_rvalid, capture word1. → RESP.
  - RESP: rsp_valid=1. On rsp_ready → IDLE.
- **Merge:**
  - Form a 2·XLEN value {word1, word0}; word1 = 0 when not crossing.
  - Shift it right by offset·8 and keep the low S·8 bits.
  - Sign-extend from bit S·8−1 for signed loads, zero-extend for unsigned. For ld, no extension.
- **Fault response:** rsp_data = 0, rsp_fault = 1, and no mem_req is ever issued.
- **Ignored input:** mem_rvalid is ignored outside WAIT0/WAIT1.
- **Output stability:** rsp_data and rsp_fault are registered and stay stable while rsp_valid is high.

## Timing
- **Reset values:** req_ready=0 while rst is high and 1 afterwards (IDLE). mem_req=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_fault=0. State = IDLE.
- **Aligned latency:** with handshake at cycle 0 and memory latency L, mem_req is asserted at cycle 1, rvalid arrives at 1+L, and rsp_valid rises at 2+L.
- **Crossing latency:** the second mem_req is at 2+L, the second rvalid at 2+2L, and rsp_valid rises at 3+2L.
- **Fault latency:** rsp_valid rises at cycle 1.
- **Response stall:** rsp_valid holds until the cycle with rsp_ready=1. The transfer completes at that edge, and req_ready returns the following cycle. Back-to-back throughput is therefore one request per 3+L cycles minimum for aligned loads.
- **Outstanding limit:** at most one request is outstanding. req_valid asserted while req_ready=0 is not accepted, and the requester holds it.
- **Reset mid-operation:** rst asserted in any state returns the unit to IDLE asynchronously and discards captured data. A late mem_rvalid after reset is ignored.
- **Address wrap:** aligned address + B wraps modulo 2^XLEN.

## Test plan
All scenarios use XLEN=32, L=1, with mem[0x100]=0xDDCCBBAA and mem[0x104]=0x44332211.
- **Aligned byte loads:**
  - lb @0x101 → rsp_data=0xFFFFFFBB, fault=0, one mem_req at 0x100, rsp_valid 3 cycles after the handshake.
  - lbu @0x101 → 0x000000BB.
- **Crossing halfword:** lh @0x103 → two mem_req (0x100, then 0x104), rsp_data=0x000011DD, rsp_valid 5 cycles after the handshake.
- **Crossing word:**
  - lw @0x102 → 0x2211DDCC.
  - With MISALIGNED_EN=0, the same request → rsp_fault=1, rsp_data=0, no mem_req, rsp_valid at cycle 1.
- **Illegal funct3:** funct3=011 at XLEN=32 → fault, rsp_data=0, no mem_req.
- **Response backpressure:** hold rsp_ready=0 for 4 cycles → rsp_valid, rsp_data and rsp_fault stay stable and req_ready stays 0. Release → IDLE the next cycle.
- **Reset mid-operation:** assert rst while in WAIT1 of lh @0x103, then deliver mem_rvalid → no rsp_valid. All outputs are at reset values, and the next lw @0x100 returns 0xDDCCBBAA.
